// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier: FSM encoding
// and the iteration counter width helper.
package seq_shift_add_multiplier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter counts N-1 down to 0, so clog2(N) bits suffice (at least one bit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_shift_add_multiplier_if.sv
// Request/result bundle between a client and the sequential multiplier.
interface seq_shift_add_multiplier_if #(
    parameter int N = 8
);
    logic             start;
    logic [N-1:0]     multiplicand;
    logic [N-1:0]     multiplier;
    logic             ready;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   product;

    modport master (
        output start, multiplicand, multiplier,
        input  ready, busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output ready, busy, done, product
    );
endinterface

// File: rtl/seq_shift_add_multiplier_adder.sv
// N-bit ripple-carry adder; the carry out of the top bit is discarded because
// the multiplier sizes its operands so that it can never be set.
module seq_shift_add_multiplier_adder #(
    parameter int N = 9
) (
    input  logic [N-1:0] number1,
    input  logic [N-1:0] number2,
    output logic [N-1:0] result
);
    logic [N-1:0] carry;

    assign carry[0] = 1'b0;

    for (genvar gi = 0; gi < N; gi++) begin : g_bit
        assign result[gi] = number1[gi] ^ number2[gi] ^ carry[gi];
        if (gi < N - 1) begin : g_carry
            assign carry[gi+1] = (number1[gi] & number2[gi]) |
                                 (carry[gi] & (number1[gi] ^ number2[gi]));
        end
    end
endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Unsigned N x N -> 2N radix-2 shift-and-add multiplier, one partial product
// per clock through a single shared adder.
module seq_shift_add_multiplier
    import seq_shift_add_multiplier_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    seq_shift_add_multiplier_if.slave bus
);
    localparam int              CNT_W    = cnt_w(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_t             state_reg;
    state_t             state_next;
    logic [N-1:0]       m_reg;
    logic [N-1:0]       q_reg;
    logic [N:0]         a_hi_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [2*N-1:0]     product_reg;

    logic [N:0]         add_out;
    logic [N:0]         sum;
    logic [2*N:0]       shifted;
    logic [N:0]         a_hi_next;
    logic [N-1:0]       q_next;

    seq_shift_add_multiplier_adder #(.N(N + 1)) u_adder (
        .number1 (a_hi_reg),
        .number2 ({1'b0, m_reg}),
        .result  (add_out)
    );

    // A_hi[N] is zero before every add, so the carry lands in sum[N] and
    // the right shift walks the low sum bit into the top of Q.
    always_comb begin
        sum       = q_reg[0] ? add_out : a_hi_reg;
        shifted   = {sum, q_reg} >> 1;
        a_hi_next = shifted[2*N:N];
        q_next    = shifted[N-1:0];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (bus.start) state_next = ST_RUN;
            ST_RUN:  if (cnt_reg == '0) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            m_reg       <= '0;
            q_reg       <= '0;
            a_hi_reg    <= '0;
            cnt_reg     <= '0;
            product_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        m_reg    <= bus.multiplicand;
                        q_reg    <= bus.multiplier;
                        a_hi_reg <= '0;
                        cnt_reg  <= CNT_LAST;
                    end
                end
                ST_RUN: begin
                    a_hi_reg <= a_hi_next;
                    q_reg    <= q_next;
                    cnt_reg  <= cnt_reg - 1'b1;
                    if (cnt_reg == '0) begin
                        product_reg <= shifted[2*N-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready   = (state_reg == ST_IDLE);
    assign bus.busy    = (state_reg == ST_RUN);
    assign bus.done    = (state_reg == ST_DONE);
    assign bus.product = product_reg;
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for the sequential multiplier: directed table, multi-cycle corner cases
// and random operands against plain A*B, at N=8 plus side instances at N=5/16.
module tb_seq_shift_add_multiplier;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_aux = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    bit   aux_fin [2];

    always #5 clk = ~clk;

    seq_shift_add_multiplier_if #(.N(N)) bus ();
    seq_shift_add_multiplier #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] p;
    } vec_t;

    vec_t table_v [6];

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one operation from IDLE; returns the product seen on the done
    // cycle and the number of cycles from the first busy cycle to done.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          output logic [2*N-1:0] p, output int lat);
        @(negedge clk);
        check("ready_before_start", 64'(bus.ready), 64'd1);
        bus.start        = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 4 * N) begin
            @(negedge clk);
            lat++;
        end
        p = bus.product;
    endtask

    initial begin
        logic [2*N-1:0] p;
        logic [N-1:0]   a, b;
        int             lat;
        int             guard;
        bit             saw_done;

        bus.start = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;

        // Reset held for three cycles
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(bus.ready), 64'd1);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_product", 64'(bus.product), 64'd0);
        rst = 1'b0;
        rst_aux = 1'b0;

        table_v[0] = '{a: 8'd13,  b: 8'd11,  p: 16'd143};
        table_v[1] = '{a: 8'd255, b: 8'd255, p: 16'd65025};
        table_v[2] = '{a: 8'd0,   b: 8'd200, p: 16'd0};
        table_v[3] = '{a: 8'd1,   b: 8'd128, p: 16'd128};
        table_v[4] = '{a: 8'd200, b: 8'd0,   p: 16'd0};
        table_v[5] = '{a: 8'd255, b: 8'd1,   p: 16'd255};

        for (int i = 0; i < 6; i++) begin
            run_op(table_v[i].a, table_v[i].b, p, lat);
            $display("table %0d: %0d * %0d -> %0d (latency %0d)", i, table_v[i].a, table_v[i].b, p, lat);
            check("table_latency", 64'(lat), 64'(N));
            check("table_product", 64'(p), 64'(table_v[i].p));
            @(negedge clk);
            check("table_done_single", 64'(bus.done), 64'd0);
            check("table_ready_after", 64'(bus.ready), 64'd1);
            check("table_product_held", 64'(bus.product), 64'(table_v[i].p));
        end

        // start held high through RUN and DONE with different operands
        @(negedge clk);
        bus.start = 1'b1;
        bus.multiplicand = 8'd13;
        bus.multiplier = 8'd11;
        @(negedge clk);
        bus.multiplicand = 8'd7;
        bus.multiplier = 8'd7;
        check("hold_busy", 64'(bus.busy), 64'd1);
        lat = 0;
        while (!bus.done && lat < 4 * N) begin
            @(negedge clk);
            lat++;
        end
        $display("hold-start: first result %0d (latency %0d)", bus.product, lat);
        check("hold_latency", 64'(lat), 64'(N));
        check("hold_first_product", 64'(bus.product), 64'd143);
        @(negedge clk);
        check("hold_idle_after_done", 64'(bus.ready), 64'd1);
        @(negedge clk);
        bus.start = 1'b0;
        check("hold_restart_busy", 64'(bus.busy), 64'd1);
        lat = 0;
        while (!bus.done && lat < 4 * N) begin
            @(negedge clk);
            lat++;
        end
        $display("hold-start: second result %0d (latency %0d)", bus.product, lat);
        check("hold_second_product", 64'(bus.product), 64'd49);
        @(negedge clk);

        // Asynchronous reset mid-RUN
        @(negedge clk);
        bus.start = 1'b1;
        bus.multiplicand = 8'd13;
        bus.multiplier = 8'd11;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_ready", 64'(bus.ready), 64'd1);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_product", 64'(bus.product), 64'd0);
        #1 rst = 1'b0;
        saw_done = 1'b0;
        repeat (N + 4) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        check("abort_no_done", 64'(saw_done), 64'd0);
        run_op(8'd3, 8'd5, p, lat);
        $display("after abort: 3 * 5 -> %0d (latency %0d)", p, lat);
        check("abort_fresh_product", 64'(p), 64'd15);
        check("abort_fresh_latency", 64'(lat), 64'(N));
        @(negedge clk);

        // Random operands against the arithmetic reference
        for (int t = 0; t < 2000; t++) begin
            a = N'($urandom_range(255));
            b = N'($urandom_range(255));
            run_op(a, b, p, lat);
            $display("rand n8 %0d: %0d * %0d -> %0d", t, a, b, p);
            check("rand_product", 64'(p), longint'(a) * longint'(b));
            check("rand_latency", 64'(lat), 64'(N));
            @(negedge clk);
        end

        guard = 0;
        while (!(aux_fin[0] && aux_fin[1]) && guard < 40000) begin
            @(negedge clk);
            guard++;
        end
        check("aux_finished", 64'(aux_fin[0] && aux_fin[1]), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Side instances at other widths, each with its own reset
    for (genvar gi = 0; gi < 2; gi++) begin : g_aux
        localparam int W   = (gi == 0) ? 5 : 16;
        localparam int OPS = (gi == 0) ? 500 : 300;

        seq_shift_add_multiplier_if #(.N(W)) abus ();
        seq_shift_add_multiplier #(.N(W)) adut (.clk(clk), .rst(rst_aux), .bus(abus));

        initial begin
            logic [W-1:0] a, b;
            int           lat;

            abus.start = 1'b0;
            abus.multiplicand = '0;
            abus.multiplier = '0;
            wait (rst_aux === 1'b0);
            for (int t = 0; t < OPS; t++) begin
                if (t == 0) begin
                    a = '1;
                    b = '1;
                end else begin
                    a = W'($urandom);
                    b = W'($urandom);
                end
                @(negedge clk);
                abus.start = 1'b1;
                abus.multiplicand = a;
                abus.multiplier = b;
                @(negedge clk);
                abus.start = 1'b0;
                lat = 0;
                while (!abus.done && lat < 4 * W) begin
                    @(negedge clk);
                    lat++;
                end
                $display("rand n%0d %0d: %0d * %0d -> %0d", W, t, a, b, abus.product);
                check($sformatf("n%0d_product", W), 64'(abus.product), longint'(a) * longint'(b));
                check($sformatf("n%0d_latency", W), 64'(lat), 64'(W));
                @(negedge clk);
            end
            aux_fin[gi] = 1'b1;
        end
    end
endmodule
